// File: rtl/param_calculator_if.sv
// Instruction/result handshake and debug-read bundle for param_calculator.
// The issuer uses the master modport; the calculator uses the slave modport.
interface param_calculator_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              use_imm;
    logic [WIDTH-1:0]  immediate;
    logic [ADDR_W-1:0] wd_addr;
    logic              out_valid;
    logic [WIDTH-1:0]  result;
    logic              carry;
    logic              zero;
    logic [ADDR_W-1:0] dbg_addr;
    logic [WIDTH-1:0]  dbg_data;

    modport master (
        output in_valid, op, rs_addr, rt_addr, use_imm, immediate, wd_addr, dbg_addr,
        input  in_ready, out_valid, result, carry, zero, dbg_data
    );

    modport slave (
        input  in_valid, op, rs_addr, rt_addr, use_imm, immediate, wd_addr, dbg_addr,
        output in_ready, out_valid, result, carry, zero, dbg_data
    );
endinterface

// File: rtl/param_calculator.sv
// Register-file calculator: single-cycle ALU ops plus a multi-cycle shift-add MUL
// that holds off new instructions until its result has been written back.
module param_calculator #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    param_calculator_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   regs [NREGS];
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [ADDR_W-1:0]  mul_dst;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               zero_q;

    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic [WIDTH:0]     wide;
    logic               accept;

    assign opa          = regs[bus.rs_addr];
    assign opb          = bus.use_imm ? bus.immediate : regs[bus.rt_addr];
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.in_ready = (state == ST_IDLE) && rst_n;
    assign bus.dbg_data = regs[bus.dbg_addr];
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;

    // One partial product per MUL cycle; the multiplicand shifts left as the multiplier shifts right.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_res   = '0;
        alu_carry = 1'b0;
        wide      = '0;
        case (bus.op)
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_ANDN: alu_res = opa & ~opb;
            OP_ORN:  alu_res = opa | ~opb;
            OP_ADD: begin
                wide      = {1'b0, opa} + {1'b0, opb};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_SUB: begin
                wide      = {1'b0, opa} + {1'b0, ~opb} + (WIDTH+1)'(1);
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                               $signed({opa[WIDTH-1], opa}) < $signed({opb[WIDTH-1], opb})};
            default: alu_res = '0;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is architecturally cleared by reset, so it lives in flops, not RAM.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            state       <= ST_IDLE;
            cnt         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            mul_dst     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && bus.op == OP_MUL) begin
                        mcand   <= {{WIDTH{1'b0}}, opa};
                        mplier  <= opb;
                        acc     <= '0;
                        cnt     <= '0;
                        mul_dst <= bus.wd_addr;
                        state   <= ST_MUL;
                    end else if (accept) begin
                        regs[bus.wd_addr] <= alu_res;
                        result_q          <= alu_res;
                        carry_q           <= alu_carry;
                        zero_q            <= (alu_res == '0);
                        out_valid_q       <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        regs[mul_dst] <= acc_next[WIDTH-1:0];
                        result_q      <= acc_next[WIDTH-1:0];
                        carry_q       <= |acc_next[2*WIDTH-1:WIDTH];
                        zero_q        <= (acc_next[WIDTH-1:0] == '0);
                        out_valid_q   <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_calculator.sv
// Directed bench for param_calculator (WIDTH=4, ADDR_W=2) with hand-computed expectations.
module tb_param_calculator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    param_calculator_if #(.WIDTH(4), .ADDR_W(2)) bus ();

    param_calculator #(.WIDTH(4), .ADDR_W(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                          input logic ui, input logic [3:0] imm, input logic [1:0] wd);
        bus.op        = op;
        bus.rs_addr   = rs;
        bus.rt_addr   = rt;
        bus.use_imm   = ui;
        bus.immediate = imm;
        bus.wd_addr   = wd;
        bus.in_valid  = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] res, input logic c, input logic z);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " result"}, 32'(bus.result), 32'(res));
        check({tag, " carry"}, 32'(bus.carry), 32'(c));
        check({tag, " zero"}, 32'(bus.zero), 32'(z));
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [3:0] exp);
        bus.dbg_addr = addr;
        #1;
        check(tag, 32'(bus.dbg_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bus.in_valid = 1'b0; bus.op = '0; bus.rs_addr = '0; bus.rt_addr = '0;
        bus.use_imm = 1'b0; bus.immediate = '0; bus.wd_addr = '0; bus.dbg_addr = '0;

        // Reset for 3 cycles
        repeat (3) tick();
        check("in_ready during reset", 32'(bus.in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) check_reg("reset reg", 2'(a), 4'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset carry", 32'(bus.carry), 32'd0);
        check("reset zero", 32'(bus.zero), 32'd0);

        // ADD with carry, back to back
        set_op(3'b010, 2'd0, 2'd0, 1'b1, 4'd9, 2'd1); tick();
        check_out("add r0+9", 4'd9, 1'b0, 1'b0);
        set_op(3'b010, 2'd1, 2'd0, 1'b1, 4'd8, 2'd1); tick();
        check_out("add r1+8", 4'd1, 1'b1, 1'b0);

        // SUB and SLT
        set_op(3'b110, 2'd1, 2'd0, 1'b1, 4'd1, 2'd2); tick();
        check_out("sub r1-1", 4'd0, 1'b1, 1'b1);
        set_op(3'b111, 2'd2, 2'd0, 1'b1, 4'b1000, 2'd3); tick();
        check_out("slt 0<-8", 4'd0, 1'b0, 1'b1);
        set_op(3'b111, 2'd2, 2'd0, 1'b1, 4'd7, 2'd3); tick();
        check_out("slt 0<7", 4'd1, 1'b0, 1'b0);
        bus.in_valid = 1'b0; tick();
        check("idle out_valid", 32'(bus.out_valid), 32'd0);
        check("idle result hold", 32'(bus.result), 32'd1);
        check_reg("r1 after add", 2'd1, 4'd1);

        // MUL 3*5 with an instruction held during the busy period
        set_op(3'b010, 2'd0, 2'd0, 1'b1, 4'd3, 2'd1); tick();
        check_out("load r1=3", 4'd3, 1'b0, 1'b0);
        set_op(3'b011, 2'd1, 2'd0, 1'b1, 4'd5, 2'd2); tick();
        set_op(3'b010, 2'd3, 2'd2, 1'b0, 4'd0, 2'd3);
        for (int i = 0; i < 4; i++) begin
            check("mul busy in_ready", 32'(bus.in_ready), 32'd0);
            check("mul busy out_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        check_out("mul 3*5", 4'd15, 1'b0, 1'b0);
        check("mul done in_ready", 32'(bus.in_ready), 32'd1);
        check_reg("r2 after mul", 2'd2, 4'd15);
        check_reg("r3 untouched while busy", 2'd3, 4'd1);
        tick();
        check_out("held add r3+r2", 4'd0, 1'b1, 1'b1);
        bus.in_valid = 1'b0; tick();
        check("held add once out_valid", 32'(bus.out_valid), 32'd0);
        check_reg("r3 after held add", 2'd3, 4'd0);

        // MUL 5*5 overflow, latency measured with a bounded wait
        set_op(3'b010, 2'd0, 2'd0, 1'b1, 4'd5, 2'd1); tick();
        check_out("load r1=5", 4'd5, 1'b0, 1'b0);
        set_op(3'b011, 2'd1, 2'd0, 1'b1, 4'd5, 2'd2); tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("mul latency", 32'(lat), 32'd4);
        check_out("mul 5*5", 4'd9, 1'b1, 1'b0);

        // Reset in the middle of a MUL (counter = 2)
        set_op(3'b011, 2'd1, 2'd0, 1'b1, 4'd5, 2'd2); tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mid-mul reset in_ready", 32'(bus.in_ready), 32'd0);
        tick(); tick();
        check("mid-mul reset out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post reset in_ready", 32'(bus.in_ready), 32'd1);
        check_reg("post reset r2", 2'd2, 4'd0);
        check_reg("post reset r1", 2'd1, 4'd0);
        for (int i = 0; i < 5; i++) begin
            check("no late mul pulse", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Dependency chain in consecutive cycles
        set_op(3'b001, 2'd0, 2'd0, 1'b1, 4'b0101, 2'd1); tick();
        check_out("or r0|5", 4'd5, 1'b0, 1'b0);
        set_op(3'b100, 2'd1, 2'd0, 1'b1, 4'b0100, 2'd1); tick();
        check_out("andn r1&~4", 4'd1, 1'b0, 1'b0);
        set_op(3'b101, 2'd1, 2'd0, 1'b1, 4'b1111, 2'd2); tick();
        check_out("orn r1|~f", 4'd1, 1'b0, 1'b0);
        set_op(3'b000, 2'd2, 2'd1, 1'b0, 4'd0, 2'd3); tick();
        check_out("and r2&r1", 4'd1, 1'b0, 1'b0);
        set_op(3'b110, 2'd0, 2'd0, 1'b1, 4'd1, 2'd3); tick();
        check_out("sub 0-1 borrow", 4'd15, 1'b0, 1'b0);
        bus.in_valid = 1'b0; tick();
        check("chain end out_valid", 32'(bus.out_valid), 32'd0);
        check_reg("r3 final", 2'd3, 4'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
